bus_uart_tx: RTL

//  Memory-mapped UART transmitter; a responder on the core's data bus (mem_read/mem_write/addr_in/data_in/byteen).
//  It decodes a 16-byte register window and buffers bytes written by software in a TX FIFO.

---
 rtl/bus_uart_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, exposed as a 16-byte register window.
// Registers: TXDATA(+0), STATUS(+4), BAUD_DIV(+8), CTRL(+C); reads return one cycle after mem_read.
module bus_uart_tx #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int               FIFO_DEPTH  = 8,
  parameter logic [15:0]      DEFAULT_DIV = 16'd434
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       byteen,
  output logic [WIDTH-1:0] mem_data_out,
  output logic             hit,
  output logic             tx,
  output logic             irq_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [15:0]   baud_q;
  logic          en_q, ie_q, ovr_q;
  logic [1:0]    state_q, state_d;
  logic [15:0]   tmr_q, tmr_d, per_q, per_d, per_new;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          tx_q, tx_d;
  logic [WIDTH-1:0] rdata_q, rdata;
  logic          hit_q;

  logic       sel, wr_en, push_req, push, pop, full, empty, busy;
  logic [1:0] off;
  logic       unused_ok;

  assign sel      = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign off      = addr_in[3:2];
  assign wr_en    = mem_write & sel;
  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign push_req = wr_en & (off == 2'd0) & byteen[0];
  // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
  assign push     = push_req & ~full;
  assign per_new  = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign unused_ok = ^{addr_in[1:0], data_in[WIDTH-1:16], byteen[3:2]};

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    per_d   = per_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (en_q && !empty) begin
        pop     = 1'b1;
        state_d = S_START;
        shf_d   = fifo_q[rd_ptr_q];
        per_d   = per_new;
        tmr_d   = per_new - 16'd1;
      end
      S_START: if (tmr_q == 16'd0) begin
        state_d = S_DATA;
        tmr_d   = per_q - 16'd1;
        bit_d   = 3'd0;
      end else tmr_d = tmr_q - 16'd1;
      S_DATA: if (tmr_q == 16'd0) begin
        tmr_d = per_q - 16'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
        else begin
          bit_d = bit_q + 3'd1;
          shf_d = shf_q >> 1;
        end
      end else tmr_d = tmr_q - 16'd1;
      default: if (tmr_q == 16'd0) state_d = S_IDLE;
               else tmr_d = tmr_q - 16'd1;
    endcase
    // Line level follows the next state so tx comes straight off a flop.
    tx_d = (state_d == S_START) ? 1'b0 : (state_d == S_DATA) ? shf_d[0] : 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (off)
      2'd1: begin
        rdata[0]    = full;
        rdata[1]    = empty;
        rdata[2]    = busy;
        rdata[3]    = ovr_q;
        rdata[15:8] = 8'(cnt_q);
      end
      2'd2:    rdata[15:0] = baud_q;
      2'd3:    rdata[1:0]  = {ie_q, en_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      baud_q   <= DEFAULT_DIV;
      en_q     <= 1'b1;
      ie_q     <= 1'b0;
      ovr_q    <= 1'b0;
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      per_q    <= 16'd1;
      bit_q    <= '0;
      shf_q    <= '0;
      tx_q     <= 1'b1;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      tx_q    <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_req && full) ovr_q <= 1'b1;
      else if (wr_en && off == 2'd1 && byteen[0] && data_in[3]) ovr_q <= 1'b0;
      if (wr_en && off == 2'd2) begin
        if (byteen[0]) baud_q[7:0]  <= data_in[7:0];
        if (byteen[1]) baud_q[15:8] <= data_in[15:8];
      end
      if (wr_en && off == 2'd3 && byteen[0]) begin
        en_q <= data_in[0];
        ie_q <= data_in[1];
      end
      if (mem_read) rdata_q <= sel ? rdata : '0;
      hit_q <= mem_read & sel;
    end
  end

  assign mem_data_out = rdata_q;
  assign hit          = hit_q;
  assign tx           = tx_q;
  assign irq_empty    = ie_q & empty & ~busy;
endmodule
